// File: rtl/pe_engine_arbiter_if.sv
// Requester and engine signals shared between the arbiter and its neighbours.
// slave: the arbiter. master: the requesters plus the engine (or a bench driving both).
interface pe_engine_arbiter_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;
  logic [1:0]        ack;
  logic              err;
  logic              busy;
  logic              grant_id;
  logic              eng_start;
  logic [ADDR_W-1:0] eng_base;
  logic              eng_abort;
  logic              eng_done;

  modport master (
    output req, base0, base1, eng_done,
    input  ack, err, busy, grant_id, eng_start, eng_base, eng_abort
  );

  modport slave (
    input  req, base0, base1, eng_done,
    output ack, err, busy, grant_id, eng_start, eng_base, eng_abort
  );
endinterface

// File: rtl/pe_engine_arbiter.sv
// Round-robin share of the single microcoded PE engine between two requesters.
// One run at a time: grant, launch, wait for done (or time out), acknowledge.
module pe_engine_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned TMO_W  = 16,
  parameter int unsigned TMO    = 40000
) (
  input logic                  clk,
  input logic                  reset,
  pe_engine_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StFinish} state_e;

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO - 1);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q;
  logic              start_q;
  logic              timeout;

  assign timeout = (timer_q == TmoLast);

  // Next-state, grant selection, timer and completion status.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    grant_d = grant_q;
    base_d  = base_q;
    err_d   = err_q;
    ack_d   = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (bus.req != 2'b00) begin
          // Both asking: the one not served last wins.
          grant_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          base_d  = grant_d ? bus.base1 : bus.base0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StRun;
      end
      StRun: begin
        timer_d = timer_q + 1'b1;
        // Done takes precedence over a timeout in the same cycle.
        if (bus.eng_done) begin
          err_d   = 1'b0;
          ack_d   = grant_q ? 2'b10 : 2'b01;
          state_d = StFinish;
        end else if (timeout) begin
          err_d   = 1'b1;
          ack_d   = grant_q ? 2'b10 : 2'b01;
          state_d = StFinish;
        end
      end
      StFinish: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      base_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      base_q  <= base_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != StIdle);
      start_q <= (state_d == StLaunch);
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.eng_start = start_q;
  assign bus.eng_base  = base_q;
  // Abort has to fall in the last RUN cycle yet yield to a same-cycle done,
  // so it is decoded from registered state and gated by eng_done.
  assign bus.eng_abort = (state_q == StRun) && timeout && !bus.eng_done;

endmodule
